// File: rtl/param_alu_core.sv
// param_alu_core: WIDTH-bit ALU with register file, flags and
// an iterative shift-add multiplier behind a valid/ready handshake.
module param_alu_core #(
    parameter  int WIDTH = 8,
    parameter  int NREGS = 8,
    localparam int AW    = $clog2(NREGS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       opcode,
    input  logic [AW-1:0]    rs1,
    input  logic [AW-1:0]    rs2,
    input  logic [AW-1:0]    rd,
    input  logic             imm_en,
    input  logic [WIDTH-1:0] imm,
    output logic [WIDTH-1:0] result,
    output logic             out_valid,
    output logic             flag_z,
    output logic             flag_c,
    output logic             flag_v,
    output logic             busy
);

    localparam int SW = $clog2(WIDTH);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic {
        S_IDLE,
        S_MUL
    } state_t;

    state_t             state;
    logic [WIDTH-1:0]   regs [NREGS];
    logic [2*WIDTH-1:0] mul_a;
    logic [2*WIDTH-1:0] mul_acc;
    logic [WIDTH-1:0]   mul_b;
    logic [CW-1:0]      mul_cnt;
    logic [AW-1:0]      mul_rd;

    logic [WIDTH-1:0]   op_a;
    logic [WIDTH-1:0]   op_b;
    logic [SW-1:0]      sh_amt;
    logic [WIDTH:0]     sum;
    logic [WIDTH:0]     diff;
    logic [2*WIDTH-1:0] shl_w;
    logic [2*WIDTH-1:0] shr_w;
    logic [WIDTH-1:0]   alu_r;
    logic               alu_c;
    logic               alu_v;
    logic               alu_wr;
    logic               alu_nop;
    logic               is_mul;
    logic [2*WIDTH-1:0] mul_next;

    assign in_ready = (state == S_IDLE);
    assign busy     = ~in_ready;

    // Operand fetch and single-cycle result/flag computation.
    always_comb begin
        op_a     = regs[rs1];
        op_b     = imm_en ? imm : regs[rs2];
        sh_amt   = op_b[SW-1:0];
        sum      = {1'b0, op_a} + {1'b0, op_b};
        diff     = {1'b0, op_a} - {1'b0, op_b};
        shl_w    = {{WIDTH{1'b0}}, op_a} << sh_amt;
        shr_w    = {op_a, {WIDTH{1'b0}}} >> sh_amt;
        mul_next = mul_acc + (mul_b[0] ? mul_a : '0);
        alu_r    = '0;
        alu_c    = 1'b0;
        alu_v    = 1'b0;
        alu_wr   = 1'b0;
        alu_nop  = 1'b0;
        is_mul   = 1'b0;
        case (opcode)
            4'd0: begin
                alu_r  = sum[WIDTH-1:0];
                alu_c  = sum[WIDTH];
                alu_v  = (op_a[WIDTH-1] == op_b[WIDTH-1]) &&
                         (sum[WIDTH-1] != op_a[WIDTH-1]);
                alu_wr = 1'b1;
            end
            4'd1: begin
                alu_r  = diff[WIDTH-1:0];
                alu_c  = diff[WIDTH];
                alu_v  = (op_a[WIDTH-1] != op_b[WIDTH-1]) &&
                         (diff[WIDTH-1] != op_a[WIDTH-1]);
                alu_wr = 1'b1;
            end
            4'd2: begin
                alu_r  = op_a & op_b;
                alu_wr = 1'b1;
            end
            4'd3: begin
                alu_r  = op_a | op_b;
                alu_wr = 1'b1;
            end
            4'd4: begin
                alu_r  = op_a ^ op_b;
                alu_wr = 1'b1;
            end
            // The last bit out lands just past the kept window.
            4'd5: begin
                alu_r  = shl_w[WIDTH-1:0];
                alu_c  = shl_w[WIDTH];
                alu_wr = 1'b1;
            end
            4'd6: begin
                alu_r  = shr_w[2*WIDTH-1:WIDTH];
                alu_c  = shr_w[WIDTH-1];
                alu_wr = 1'b1;
            end
            4'd7: is_mul = 1'b1;
            4'd8: begin
                alu_r  = imm;
                alu_wr = 1'b1;
            end
            default: alu_nop = 1'b1;
        endcase
    end

    // Issue, writeback and the two-state multiply sequencer.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= S_IDLE;
            for (int i = 0; i < NREGS; i++) regs[i] <= '0;
            mul_a     <= '0;
            mul_acc   <= '0;
            mul_b     <= '0;
            mul_cnt   <= '0;
            mul_rd    <= '0;
            result    <= '0;
            out_valid <= 1'b0;
            flag_z    <= 1'b0;
            flag_c    <= 1'b0;
            flag_v    <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (in_valid && is_mul) begin
                        mul_a   <= {{WIDTH{1'b0}}, op_a};
                        mul_b   <= op_b;
                        mul_acc <= '0;
                        mul_cnt <= CW'(WIDTH);
                        mul_rd  <= rd;
                        state   <= S_MUL;
                    end else if (in_valid) begin
                        result    <= alu_r;
                        flag_z    <= ~alu_nop & (alu_r == '0);
                        flag_c    <= alu_c;
                        flag_v    <= alu_v;
                        out_valid <= 1'b1;
                        if (alu_wr) regs[rd] <= alu_r;
                    end
                end
                S_MUL: begin
                    if (mul_cnt == CW'(1)) begin
                        regs[mul_rd] <= mul_next[WIDTH-1:0];
                        result       <= mul_next[WIDTH-1:0];
                        flag_z       <= (mul_next[WIDTH-1:0] == '0);
                        flag_c       <= |mul_next[2*WIDTH-1:WIDTH];
                        flag_v       <= 1'b0;
                        out_valid    <= 1'b1;
                        state        <= S_IDLE;
                    end else begin
                        mul_acc <= mul_next;
                        mul_a   <= mul_a << 1;
                        mul_b   <= mul_b >> 1;
                        mul_cnt <= mul_cnt - CW'(1);
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_param_alu_core.sv
// tb_param_alu_core: directed self-checking bench for param_alu_core
// (WIDTH=8, NREGS=8).
module tb_param_alu_core;

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] opcode;
    logic [2:0] rs1;
    logic [2:0] rs2;
    logic [2:0] rd;
    logic       imm_en;
    logic [7:0] imm;
    logic [7:0] result;
    logic       out_valid;
    logic       flag_z;
    logic       flag_c;
    logic       flag_v;
    logic       busy;

    int n_checks = 0;
    int n_errors = 0;

    // {out_valid, result, Z, C, V}
    logic [11:0] obs;
    assign obs = {out_valid, result, flag_z, flag_c, flag_v};

    param_alu_core #(.WIDTH(8), .NREGS(8)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .opcode   (opcode),
        .rs1      (rs1),
        .rs2      (rs2),
        .rd       (rd),
        .imm_en   (imm_en),
        .imm      (imm),
        .result   (result),
        .out_valid(out_valid),
        .flag_z   (flag_z),
        .flag_c   (flag_c),
        .flag_v   (flag_v),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Present one instruction, return 1 time unit after its accept edge.
    task automatic issue(input logic [3:0] op, input logic [2:0] d,
                         input logic [2:0] s1, input logic [2:0] s2,
                         input logic ie, input logic [7:0] iv);
        opcode = op; rd = d; rs1 = s1; rs2 = s2;
        imm_en = ie; imm = iv; in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0; in_valid = 1'b0; opcode = '0; rs1 = '0; rs2 = '0;
        rd = '0; imm_en = 1'b0; imm = '0;
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if ({busy, in_ready, obs} !== {1'b0, 1'b1, 12'h000}) begin
            n_errors++;
            $display("FAIL reset: got %h want %h",
                     {busy, in_ready, obs}, {1'b0, 1'b1, 12'h000});
        end
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_load_add();
        issue(4'd8, 3'd1, 3'd0, 3'd0, 1'b0, 8'h05);
        n_checks++;
        if (obs !== {1'b1, 8'h05, 3'b000}) begin
            n_errors++;
            $display("FAIL ldi_r1: got %h want %h", obs, {1'b1, 8'h05, 3'b000});
        end
        issue(4'd8, 3'd2, 3'd0, 3'd0, 1'b1, 8'h04);
        n_checks++;
        if (obs !== {1'b1, 8'h04, 3'b000}) begin
            n_errors++;
            $display("FAIL ldi_r2: got %h want %h", obs, {1'b1, 8'h04, 3'b000});
        end
        issue(4'd0, 3'd3, 3'd1, 3'd2, 1'b0, 8'h00);
        n_checks++;
        if (obs !== {1'b1, 8'h09, 3'b000}) begin
            n_errors++;
            $display("FAIL add_r3: got %h want %h", obs, {1'b1, 8'h09, 3'b000});
        end
        issue(4'd0, 3'd4, 3'd3, 3'd3, 1'b0, 8'h00);
        n_checks++;
        if (obs !== {1'b1, 8'h12, 3'b000}) begin
            n_errors++;
            $display("FAIL add_r4: got %h want %h", obs, {1'b1, 8'h12, 3'b000});
        end
        @(posedge clk);
        #1;
        n_checks++;
        if (obs !== {1'b0, 8'h12, 3'b000}) begin
            n_errors++;
            $display("FAIL idle_hold: got %h want %h", obs, {1'b0, 8'h12, 3'b000});
        end
    endtask

    task automatic test_flags();
        issue(4'd8, 3'd1, 3'd0, 3'd0, 1'b1, 8'h7F);
        issue(4'd0, 3'd2, 3'd1, 3'd0, 1'b1, 8'h01);
        n_checks++;
        if (obs !== {1'b1, 8'h80, 3'b001}) begin
            n_errors++;
            $display("FAIL add_ovf: got %h want %h", obs, {1'b1, 8'h80, 3'b001});
        end
        issue(4'd8, 3'd1, 3'd0, 3'd0, 1'b1, 8'hFF);
        issue(4'd0, 3'd2, 3'd1, 3'd0, 1'b1, 8'h01);
        n_checks++;
        if (obs !== {1'b1, 8'h00, 3'b110}) begin
            n_errors++;
            $display("FAIL add_carry: got %h want %h", obs, {1'b1, 8'h00, 3'b110});
        end
        issue(4'd8, 3'd1, 3'd0, 3'd0, 1'b1, 8'h03);
        issue(4'd1, 3'd2, 3'd1, 3'd0, 1'b1, 8'h05);
        n_checks++;
        if (obs !== {1'b1, 8'hFE, 3'b010}) begin
            n_errors++;
            $display("FAIL sub_borrow: got %h want %h", obs, {1'b1, 8'hFE, 3'b010});
        end
        issue(4'd2, 3'd2, 3'd1, 3'd0, 1'b1, 8'h01);
        n_checks++;
        if (obs !== {1'b1, 8'h01, 3'b000}) begin
            n_errors++;
            $display("FAIL and_flags: got %h want %h", obs, {1'b1, 8'h01, 3'b000});
        end
    endtask

    task automatic test_shifts();
        issue(4'd8, 3'd1, 3'd0, 3'd0, 1'b1, 8'h81);
        issue(4'd5, 3'd2, 3'd1, 3'd0, 1'b1, 8'h01);
        n_checks++;
        if (obs !== {1'b1, 8'h02, 3'b010}) begin
            n_errors++;
            $display("FAIL shl1: got %h want %h", obs, {1'b1, 8'h02, 3'b010});
        end
        issue(4'd6, 3'd2, 3'd1, 3'd0, 1'b1, 8'h09);
        n_checks++;
        if (obs !== {1'b1, 8'h40, 3'b010}) begin
            n_errors++;
            $display("FAIL shr9: got %h want %h", obs, {1'b1, 8'h40, 3'b010});
        end
        issue(4'd5, 3'd2, 3'd1, 3'd0, 1'b1, 8'h00);
        n_checks++;
        if (obs !== {1'b1, 8'h81, 3'b000}) begin
            n_errors++;
            $display("FAIL shl0: got %h want %h", obs, {1'b1, 8'h81, 3'b000});
        end
    endtask

    task automatic test_mul();
        int  n;
        bit  ready_seen;
        issue(4'd8, 3'd1, 3'd0, 3'd0, 1'b1, 8'h0C);
        issue(4'd8, 3'd2, 3'd0, 3'd0, 1'b1, 8'h0B);
        issue(4'd7, 3'd3, 3'd1, 3'd2, 1'b0, 8'h00);
        n_checks++;
        if ({busy, in_ready, out_valid} !== 3'b100) begin
            n_errors++;
            $display("FAIL mul_busy: got %b want %b",
                     {busy, in_ready, out_valid}, 3'b100);
        end
        n = 0;
        ready_seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            n++;
            if (out_valid) break;
            if (in_ready) ready_seen = 1'b1;
        end
        n_checks++;
        if (n !== 8) begin
            n_errors++;
            $display("FAIL mul_latency: got %0d want %0d", n, 8);
        end
        n_checks++;
        if (ready_seen !== 1'b0) begin
            n_errors++;
            $display("FAIL mul_ready_low: got %b want %b", ready_seen, 1'b0);
        end
        n_checks++;
        if ({in_ready, obs} !== {1'b1, 1'b1, 8'h84, 3'b000}) begin
            n_errors++;
            $display("FAIL mul_0c_0b: got %h want %h",
                     {in_ready, obs}, {1'b1, 1'b1, 8'h84, 3'b000});
        end
        issue(4'd8, 3'd1, 3'd0, 3'd0, 1'b1, 8'h10);
        issue(4'd7, 3'd4, 3'd1, 3'd0, 1'b1, 8'h10);
        for (int i = 0; i < 20; i++) begin
            if (out_valid) break;
            @(posedge clk);
            #1;
        end
        n_checks++;
        if (obs !== {1'b1, 8'h00, 3'b110}) begin
            n_errors++;
            $display("FAIL mul_ovf: got %h want %h", obs, {1'b1, 8'h00, 3'b110});
        end
    endtask

    task automatic test_busy_ignore();
        issue(4'd8, 3'd1, 3'd0, 3'd0, 1'b1, 8'h02);
        issue(4'd7, 3'd2, 3'd1, 3'd0, 1'b1, 8'h03);
        opcode = 4'd8; rd = 3'd5; imm_en = 1'b1; imm = 8'hAA;
        in_valid = 1'b1;
        for (int i = 0; i < 7; i++) begin
            @(posedge clk);
            #1;
            n_checks++;
            if (out_valid !== 1'b0) begin
                n_errors++;
                $display("FAIL busy_no_issue: cycle %0d got %b want %b",
                         i, out_valid, 1'b0);
            end
        end
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        n_checks++;
        if (obs !== {1'b1, 8'h06, 3'b000}) begin
            n_errors++;
            $display("FAIL mul_2_3: got %h want %h", obs, {1'b1, 8'h06, 3'b000});
        end
        issue(4'd0, 3'd6, 3'd5, 3'd0, 1'b1, 8'h00);
        n_checks++;
        if (obs !== {1'b1, 8'h00, 3'b100}) begin
            n_errors++;
            $display("FAIL r5_untouched: got %h want %h", obs, {1'b1, 8'h00, 3'b100});
        end
    endtask

    task automatic test_nop();
        issue(4'd8, 3'd1, 3'd0, 3'd0, 1'b1, 8'h33);
        issue(4'd12, 3'd1, 3'd1, 3'd1, 1'b1, 8'h55);
        n_checks++;
        if (obs !== {1'b1, 8'h00, 3'b000}) begin
            n_errors++;
            $display("FAIL nop: got %h want %h", obs, {1'b1, 8'h00, 3'b000});
        end
        issue(4'd0, 3'd5, 3'd1, 3'd0, 1'b1, 8'h00);
        n_checks++;
        if (obs !== {1'b1, 8'h33, 3'b000}) begin
            n_errors++;
            $display("FAIL nop_no_write: got %h want %h", obs, {1'b1, 8'h33, 3'b000});
        end
    endtask

    task automatic test_mul_reset();
        bit pulse;
        issue(4'd8, 3'd1, 3'd0, 3'd0, 1'b1, 8'h03);
        issue(4'd7, 3'd7, 3'd1, 3'd0, 1'b1, 8'h02);
        repeat (3) @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        n_checks++;
        if ({busy, in_ready, obs} !== {1'b0, 1'b1, 12'h000}) begin
            n_errors++;
            $display("FAIL mid_mul_reset: got %h want %h",
                     {busy, in_ready, obs}, {1'b0, 1'b1, 12'h000});
        end
        @(negedge clk);
        rst = 1'b1;
        pulse = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk);
            #1;
            if (out_valid || busy) pulse = 1'b1;
        end
        n_checks++;
        if (pulse !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_no_writeback: got %b want %b", pulse, 1'b0);
        end
        issue(4'd0, 3'd5, 3'd7, 3'd0, 1'b1, 8'h00);
        n_checks++;
        if (obs !== {1'b1, 8'h00, 3'b100}) begin
            n_errors++;
            $display("FAIL r7_after_reset: got %h want %h", obs, {1'b1, 8'h00, 3'b100});
        end
    endtask

    initial begin
        test_reset();
        test_load_add();
        test_flags();
        test_shifts();
        test_mul();
        test_busy_ignore();
        test_nop();
        test_mul_reset();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/param_alu_core.md
Name: param_alu_core

Overview:
- Parametrised successor to the team's 4-bit ALU: WIDTH-bit datapath, NREGS-entry register file, immediate operand, status flags, iterative multiply.
- Accepts one instruction per valid/ready handshake, reads two source registers (or one register plus an immediate), writes the result back to a destination register and presents it on a registered result port.
- Sits between the instruction sequencer and the 7-segment/result display path.

Parameters:
- WIDTH, 8, datapath and register width (>=4).
- NREGS, 8, register-file depth (power of 2, >=2); AW = clog2(NREGS).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- in_valid  in  1  instruction present.
- in_ready  out  1  core can accept an instruction.
- opcode  in  4  operation select.
- rs1  in  AW  source register A.
- rs2  in  AW  source register B.
- rd  in  AW  destination register.
- imm_en  in  1  1: operand B = imm; 0: operand B = reg[rs2].
- imm  in  WIDTH  immediate operand.
- result  out  WIDTH  last completed result (registered).
- out_valid  out  1  one-cycle pulse per completed instruction.
- flag_z  out  1  result == 0.
- flag_c  out  1  carry/borrow/shift-out/multiply-overflow.
- flag_v  out  1  signed overflow (ADD/SUB only).
- busy  out  1  multiply in progress (= ~in_ready).

Behaviour:
- Reset (rst=0, asynchronous): all registers 0; result 0; out_valid 0; flags 0; busy 0; in_ready 1; multiply state is abandoned and no writeback occurs.
- Accept: in_valid & in_ready at a rising edge. Operands are sampled at that edge.
- Opcodes:
  - 0 ADD: A+B.
  - 1 SUB: A-B; C = borrow (A<B unsigned).
  - 2 AND, 3 OR, 4 XOR.
  - 5 SHL, 6 SHR (logical): shift amount = B[clog2(WIDTH)-1:0]; C = last bit shifted out; C = 0 when the amount is 0.
  - 7 MUL: unsigned; result = low WIDTH bits; C = 1 if any high bit is nonzero.
  - 8 LDI: result = imm (regardless of imm_en).
  - 9-15: reserved NOP. out_valid pulses, result = 0, flags = 0, no register write.
- Flags: V is set only for ADD/SUB signed overflow and is 0 otherwise. C is 0 for AND/OR/XOR/LDI. Z is set from the WIDTH-bit result.
- Single-cycle ops (0-6, 8, NOP): computed combinationally. At the accepting edge, reg[rd], result and the flags are all written, and out_valid=1 for the following cycle. in_ready stays 1, so back-to-back issue is allowed. The next instruction reads the updated register file; no hazard or forwarding is needed.
- MUL: two-state FSM, IDLE and MUL.
  - At the accepting edge, capture A and B, clear the accumulator, set the count to WIDTH, and go to MUL (busy=1, in_ready=0).
  - Each MUL cycle does one shift-add step.
  - The result is written to reg[rd]/result/flags, with out_valid=1, at the edge WIDTH cycles after acceptance; the FSM returns to IDLE on that same edge.
  - in_ready is 1 in the cycle out_valid is 1.
  - in_valid during MUL is ignored and not queued.
  - rd == rs1 or rd == rs2 is legal; sources are captured at acceptance.
- out_valid is 0 in all cycles without a completion. result and flags hold until the next completion.
- Writing reg[rd] when rd equals a source of the same instruction uses the old source value.

Test Plan:
- Reset/flags: assert rst=0 mid-MUL (after 3 cycles), release → busy=0, in_ready=1, result=0, flags=0, destination register unchanged (still 0).
- Load and add: LDI r1=0x05, LDI r2=0x04, ADD r3=r1+r2 issued back-to-back → three out_valid pulses; result 0x09, Z=0, C=0, V=0; next ADD r4=r3+r3 → 0x12.
- Overflow/borrow/zero:
  - ADD 0x7F+imm 0x01 → 0x80, V=1, C=0.
  - ADD 0xFF+imm 0x01 → 0x00, Z=1, C=1.
  - SUB 0x03-imm 0x05 → 0xFE, C=1.
- Shifts: SHL 0x81 by imm 1 → 0x02, C=1. SHR 0x81 by imm 9 (amount 1) → 0x40, C=1. SHL by 0 → unchanged, C=0.
- Multiply:
  - MUL 0x0C×0x0B → in_ready low for 8 cycles; out_valid exactly 8 cycles after accept; result 0x84, C=0.
  - MUL 0x10×0x10 → 0x00, Z=1, C=1.
  - An instruction presented with in_valid=1 during busy is not executed.
- Reserved opcode 12 with rd=r1 → out_valid pulse, result 0, r1 unchanged (checked by a following ADD r5=r1+imm 0).
